// File: rtl/apb_pkg.sv
// Shared definitions for the APB FIFO completer: register offsets, FSM states,
// and bit positions inside CTRL and STATUS.
package apb_pkg;

    localparam int APB_AW = 4;
    localparam int APB_DW = 32;

    // Register index taken from PADDR[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_CLR_BIT      = 1;
    localparam int STATUS_EMPTY_BIT  = 0;
    localparam int STATUS_FULL_BIT   = 1;
    localparam int STATUS_COUNT_LSB  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_fifo_completer_if.sv
// APB completer bus bundle: the manager drives select/control/write data,
// the completer answers with read data, ready and error.
interface apb_fifo_completer_if;
    import apb_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush; the head word is visible without a
// pop so the completer can return it in the same cycle the pop is committed.
module sync_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/apb_fifo_completer.sv
// APB completer exposing CTRL/STATUS/DATA/SCRATCH over a sync FIFO, with a
// fixed number of wait states and PSLVERR on illegal accesses.
module apb_fifo_completer
    import apb_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_fifo_completer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    apb_state_e        state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              en_q, en_d;
    logic [APB_DW-1:0] scratch_q, scratch_d;

    logic              pready, perr, commit, access_err;
    logic [APB_DW-1:0] prdata, status_word, read_word;
    logic [1:0]        reg_sel;
    logic              unused_addr_bits;

    logic              fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic [APB_DW-1:0] fifo_rdata;
    logic [CW-1:0]     fifo_count;

    assign reg_sel          = bus.PADDR[3:2];
    assign unused_addr_bits = ^bus.PADDR[1:0];

    assign access_err = (bus.PWRITE && reg_sel == REG_STATUS) ||
                        (reg_sel == REG_DATA &&
                         (!en_q || (bus.PWRITE ? fifo_full : fifo_empty)));

    always_comb begin
        status_word                             = '0;
        status_word[STATUS_EMPTY_BIT]           = fifo_empty;
        status_word[STATUS_FULL_BIT]            = fifo_full;
        status_word[STATUS_COUNT_LSB +: CW]     = fifo_count;
        read_word                               = '0;
        case (reg_sel)
            REG_CTRL:    read_word[CTRL_EN_BIT] = en_q;
            REG_STATUS:  read_word              = status_word;
            REG_DATA:    read_word              = fifo_rdata;
            default:     read_word              = scratch_q;
        endcase
    end

    // Completion happens combinationally in the last ACCESS cycle; the
    // registered side effects land on the edge that closes it.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pready  = 1'b0;
        perr    = 1'b0;
        commit  = 1'b0;
        prdata  = '0;
        case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    state_d = ACCESS;
                    wait_d  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else if (bus.PENABLE) begin
                    if (wait_q != 4'd0) begin
                        wait_d = wait_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        pready  = 1'b1;
                        perr    = access_err;
                        commit  = !access_err;
                        if (!access_err && !bus.PWRITE) prdata = read_word;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        scratch_d = scratch_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_clr  = 1'b0;
        if (commit) begin
            if (bus.PWRITE) begin
                case (reg_sel)
                    REG_CTRL: begin
                        en_d     = bus.PWDATA[CTRL_EN_BIT];
                        fifo_clr = bus.PWDATA[CTRL_CLR_BIT];
                    end
                    REG_DATA:    fifo_push = 1'b1;
                    REG_SCRATCH: scratch_d = bus.PWDATA;
                    default:     ;
                endcase
            end else if (reg_sel == REG_DATA) begin
                fifo_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            en_q      <= 1'b0;
            scratch_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            en_q      <= en_d;
            scratch_q <= scratch_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (APB_DW)
    ) u_fifo (
        .clk     (PCLK),
        .rst_n   (PRESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clr_i   (fifo_clr),
        .wdata_i (bus.PWDATA),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.PREADY  = pready;
    assign bus.PSLVERR = perr;
    assign bus.PRDATA  = prdata;

endmodule

// File: tb/tb_apb_fifo_completer.sv
// Scoreboard bench for apb_fifo_completer: a queue-based reference model
// predicts each response, a negedge monitor compares what the DUT presents.
module tb_apb_fifo_completer;

    localparam int DEPTH = 8;
    localparam int WS    = 3;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_fifo_completer_if bus();

    apb_fifo_completer #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          setup;
        bit          wr;
        logic [3:0]  addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          txn_no = 0;
    bit          mon_en = 1'b0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_en      = 1'b0;
    logic [31:0] m_scratch = 32'h0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic void model_reset();
        mq.delete();
        m_en      = 1'b0;
        m_scratch = 32'h0;
    endfunction

    function automatic void model(input bit wr, input logic [3:0] addr,
                                  input logic [31:0] wd,
                                  output logic [31:0] rd, output bit err);
        rd  = 32'h0;
        err = 1'b0;
        case (addr[3:2])
            2'd0: begin
                if (wr) begin
                    if (wd[1]) mq.delete();
                    m_en = wd[0];
                end else begin
                    rd = m_en ? 32'h1 : 32'h0;
                end
            end
            2'd1: begin
                if (wr) err = 1'b1;
                else    rd  = (mq.size() << 16) | ((mq.size() == DEPTH) ? 2 : 0)
                              | ((mq.size() == 0) ? 1 : 0);
            end
            2'd2: begin
                if (!m_en)                      err = 1'b1;
                else if (wr && mq.size() == DEPTH) err = 1'b1;
                else if (!wr && mq.size() == 0)    err = 1'b1;
                else if (wr)                       mq.push_back(wd);
                else                               rd = mq.pop_front();
            end
            default: begin
                if (wr) m_scratch = wd;
                else    rd        = m_scratch;
            end
        endcase
        if (err) rd = 32'h0;
    endfunction

    task automatic xfer(input bit wr, input logic [3:0] addr, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] rd;
        bit          err;
        int          n;
        model(wr, addr, wd, rd, err);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wd;
        e.rdata = rd;
        e.err   = err;
        e.setup = cyc;
        e.wr    = wr;
        e.addr  = addr;
        sb.push_back(e);
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!bus.PREADY && n < 40);
        if (!bus.PREADY) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h: PREADY never rose within %0d cycles", addr, n);
            sb.delete(sb.size() - 1);
        end
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    // DATA write interrupted by reset partway through its wait states.
    task automatic reset_mid_write(input logic [31:0] wd);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 4'h8;
        bus.PWDATA  = wd;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        PRESET      = 1'b1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        model_reset();
        $display("txn reset during DATA write access");
    endtask

    // Setup followed by PSEL dropping: the completer must forget it.
    task automatic aborted_write(input logic [31:0] wd);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 4'h8;
        bus.PWDATA  = wd;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        @(posedge PCLK); #1;
        $display("txn aborted DATA write");
    endtask

    always @(negedge PCLK) begin
        exp_t e;
        int   lat;
        if (mon_en) begin
            if (bus.PREADY === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready: PREADY=1 with no transfer outstanding");
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.setup;
                    txn_no++;
                    $display("txn %0d %s addr=%h prdata=%h pslverr=%0d latency=%0d",
                             txn_no, e.wr ? "WR" : "RD", e.addr, bus.PRDATA, bus.PSLVERR, lat);
                    checks++;
                    if (bus.PRDATA !== e.rdata) begin
                        errors++;
                        $display("FAIL prdata addr=%h: got %h expected %h", e.addr, bus.PRDATA, e.rdata);
                    end
                    checks++;
                    if (bus.PSLVERR !== e.err) begin
                        errors++;
                        $display("FAIL pslverr addr=%h: got %0d expected %0d", e.addr, bus.PSLVERR, e.err);
                    end
                    checks++;
                    if (lat != 1 + WS) begin
                        errors++;
                        $display("FAIL latency addr=%h: got %0d expected %0d", e.addr, lat, 1 + WS);
                    end
                end
            end else begin
                checks++;
                if (bus.PREADY !== 1'b0 || bus.PRDATA !== 32'h0 || bus.PSLVERR !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: PREADY=%b PRDATA=%h PSLVERR=%b expected 0/0/0",
                             bus.PREADY, bus.PRDATA, bus.PSLVERR);
                end
            end
        end
    end

    initial begin
        logic [3:0]  addr;
        logic [31:0] wd;
        int          r;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 4'h0;
        bus.PWDATA  = 32'h0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        mon_en = 1'b1;

        // Reset state and basic FIFO traffic
        xfer(1'b0, 4'h4, 32'h0);
        xfer(1'b1, 4'h0, 32'h1);
        xfer(1'b1, 4'h8, 32'h12345678);
        xfer(1'b1, 4'h8, 32'hDEADBEEF);
        xfer(1'b0, 4'h8, 32'h0);
        xfer(1'b0, 4'h8, 32'h0);
        xfer(1'b0, 4'h4, 32'h0);

        // Scratch with wait states
        xfer(1'b1, 4'hC, 32'hCAFEBABE);
        xfer(1'b0, 4'hC, 32'h0);

        // Fill to full, overflow attempt, disabled access
        for (int i = 0; i < DEPTH; i++) xfer(1'b1, 4'h8, $urandom);
        xfer(1'b0, 4'h4, 32'h0);
        xfer(1'b1, 4'h8, 32'h55AA55AA);
        xfer(1'b0, 4'h4, 32'h0);
        xfer(1'b1, 4'h0, 32'h0);
        xfer(1'b0, 4'h8, 32'h0);
        xfer(1'b1, 4'h0, 32'h1);

        // Drain to 5 entries, then flush with EN kept
        for (int i = 0; i < 3; i++) xfer(1'b0, 4'h8, 32'h0);
        xfer(1'b1, 4'h0, 32'h3);
        xfer(1'b0, 4'h4, 32'h0);
        xfer(1'b0, 4'h0, 32'h0);
        xfer(1'b1, 4'h4, 32'hFFFFFFFF);
        xfer(1'b0, 4'h8, 32'h0);

        // Reset in the middle of an access
        xfer(1'b1, 4'h8, 32'h0BADF00D);
        reset_mid_write(32'h13572468);
        xfer(1'b0, 4'h4, 32'h0);
        xfer(1'b0, 4'h0, 32'h0);
        xfer(1'b0, 4'hC, 32'h0);

        // Aborted transfer leaves no trace
        xfer(1'b1, 4'h0, 32'h1);
        aborted_write(32'h2468ACE0);
        xfer(1'b0, 4'h4, 32'h0);

        // Randomised traffic, back-to-back or with idle gaps
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      addr = 4'h8;
            else if (r <= 6) addr = 4'h4;
            else if (r == 7) addr = 4'hC;
            else             addr = 4'h0;
            addr[1:0] = 2'($urandom);
            wd = $urandom;
            if (addr[3:2] == 2'd0) begin
                r  = $urandom_range(0, 7);
                wd = (r == 0) ? 32'h3 : ((r == 1) ? 32'h0 : 32'h1);
            end
            xfer(1'($urandom), addr, wd);
            repeat ($urandom_range(0, 2)) begin
                @(posedge PCLK); #1;
            end
        end

        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_fifo_completer.md
# apb_fifo_completer

APB completer (slave) that fronts an internal synchronous FIFO behind four word-aligned registers, with a parameterised number of wait states and PSLVERR signalling. It is the responder counterpart to the APB manager: it sits on one PSELx/PRDATAx/PREADYx/PSLVERRx slot of the manager's decoder and exercises wait-state and error paths that the plain register slave does not.

## Interface
Parameters:
- DEPTH, 8, FIFO entries (power of two, 2..256)
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion (0..15)

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset; one clock, reset is synchronous and active-low
- PSEL  in  1  slot select from manager decoder
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  4  byte address; [3:2] selects register, [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data, valid only while PREADY = 1, else 0
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error, valid only while PREADY = 1, else 0

## Operation
- Register map: 0x0 CTRL (RW: [0] EN, [1] CLR write-only, reads 0); 0x4 STATUS (RO: [0] EMPTY, [1] FULL, [16+:$clog2(DEPTH)+1] COUNT); 0x8 DATA (write = push PWDATA, read = pop head); 0xC SCRATCH (RW 32 bits).
- FSM states IDLE, ACCESS.
  - IDLE: PSEL=1 & PENABLE=0 (setup) -> ACCESS, wait counter loaded with WAIT_STATES.
  - ACCESS: PSEL=1 & PENABLE=1 & counter>0 -> counter decrements, stay.
  - ACCESS: PSEL=1 & PENABLE=1 & counter=0 -> PREADY=1 combinationally; next state IDLE.
  - ACCESS: PSEL=0 (aborted transfer) -> IDLE, no side effect.
- All side effects (register write, push, pop, CLR flush) occur on the rising edge that ends the PREADY=1 cycle, and only when PSLVERR=0.
- PSLVERR=1 when: write to STATUS; DATA access with CTRL.EN=0; DATA write with FULL; DATA read with EMPTY. Errored transfer: no state change, PRDATA=0.
- CLR=1 write: FIFO flushed (COUNT=0); EN takes PWDATA[0] in the same write.
- COUNT width $clog2(DEPTH)+1 so that DEPTH is representable; pointers wrap modulo DEPTH.
- Back-to-back: a new setup phase is accepted in the cycle after PREADY=1 (IDLE).

## Timing
- Reset (PRESET=0 at a rising edge): state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, CTRL=0, SCRATCH=0, FIFO empty. Reset during ACCESS aborts the transfer with no side effect.
- Latency: setup at cycle T, PREADY=1 at cycle T+1+WAIT_STATES. WAIT_STATES=0 gives zero-wait APB.
- PRDATA of DATA read = head entry before the pop; STATUS read reflects state before the completing edge.
- Push to full/pop from empty impossible by construction (errored); FIFO never overflows/underflows.
- PREADY, PRDATA, PSLVERR are combinational from registered state and the current PSEL/PENABLE/PADDR/PWRITE; no combinational path from PWDATA to any output.

## Structure
- Shared package apb_pkg: register offset constants (CTRL/STATUS/DATA/SCRATCH), state enum (IDLE, ACCESS), CTRL bit indices.
- One sub-module: sync_fifo (DEPTH, 32-bit width, push/pop/clr, full/empty/count). Completer FSM, wait counter, register file and decode live in apb_fifo_completer.

## Test plan
- Reset, then read STATUS (0x4), WAIT_STATES=0 -> PREADY one cycle after setup, PRDATA=0x0000_0001 (EMPTY), PSLVERR=0.
- Write CTRL=0x1, push 0x12345678, 0xDEADBEEF to 0x8, read 0x8 twice -> PRDATA 0x12345678 then 0xDEADBEEF, STATUS then 0x0000_0001.
- WAIT_STATES=3: write SCRATCH=0xCAFEBABE -> PREADY low for 3 access cycles, high on 4th; readback 0xCAFEBABE.
- DEPTH=8: push 8 words -> STATUS=0x0008_0002; 9th push -> PSLVERR=1, COUNT stays 8; read DATA with EN=0 -> PSLVERR=1, PRDATA=0.
- Write CTRL=0x3 with 5 entries queued -> STATUS=0x0000_0001, EN=1; write STATUS -> PSLVERR=1.
- Assert PRESET=0 during ACCESS of a DATA write with WAIT_STATES=2 -> PREADY=0 next cycle, FIFO empty, CTRL=0.
